nvdla_dbb_initiator: RTL and testbench

- DBB initiator: the counterpart of the DBB-to-HWPE bridge, which acts as the DBB responder.
- A local controller issues one read or write command. The block drives the NVDLA DBB request, write-data and read-data channels and consumes the write-response channel.
- Write path packs 32-bit HWPE stream words into DBB_DW-bit beats. Read path splits DBB_DW-bit beats into 32-bit HWPE stream words.
- Used to feed a DBB responder from cluster-side HWPE streams, e.g. for loopback verification and DMA-style transfers.

---
 rtl/nvdla_dbb_initiator.sv | 264 ++++++++++++++++++++++++++
 tb/tb_nvdla_dbb_initiator.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nvdla_dbb_initiator.sv
// NVDLA DBB initiator: issues one read or write transaction at a time and converts
// between 32-bit HWPE stream words and DBB_DW-bit beats. Optional id check: NVDLA_DBB_INIT_ID_CHECK_EN.
module nvdla_dbb_initiator #(
  parameter int DBB_DW = 64,
  parameter int DBB_AW = 64,
  parameter int ID_W   = 8,
  parameter int LEN_W  = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clear_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic                cmd_write_i,
  input  logic [DBB_AW-1:0]   cmd_addr_i,
  input  logic [LEN_W-1:0]    cmd_len_i,
  input  logic [ID_W-1:0]     cmd_id_i,
  input  logic                wr_s_valid_i,
  output logic                wr_s_ready_o,
  input  logic [31:0]         wr_s_data_i,
  input  logic [3:0]          wr_s_strb_i,
  output logic                rd_s_valid_o,
  input  logic                rd_s_ready_i,
  output logic [31:0]         rd_s_data_o,
  output logic [3:0]          rd_s_strb_o,
  output logic                dbb_req_valid_o,
  input  logic                dbb_req_ready_i,
  output logic                dbb_req_write_o,
  output logic [DBB_AW-1:0]   dbb_req_addr_o,
  output logic [LEN_W-1:0]    dbb_req_len_o,
  output logic [ID_W-1:0]     dbb_req_id_o,
  output logic                dbb_wd_valid_o,
  input  logic                dbb_wd_ready_i,
  output logic [DBB_DW-1:0]   dbb_wd_data_o,
  output logic [DBB_DW/8-1:0] dbb_wd_strb_o,
  output logic                dbb_wd_last_o,
  input  logic                dbb_wr_rsp_valid_i,
  output logic                dbb_wr_rsp_ready_o,
  input  logic [ID_W-1:0]     dbb_wr_rsp_id_i,
  input  logic                dbb_rd_valid_i,
  output logic                dbb_rd_ready_o,
  input  logic [DBB_DW-1:0]   dbb_rd_data_i,
  input  logic [ID_W-1:0]     dbb_rd_id_i,
  input  logic                dbb_rd_last_i,
  output logic                done_o,
  output logic                err_o
);

  localparam int R    = DBB_DW / 32;
  localparam int WI_W = (R > 1) ? $clog2(R) : 1;
  localparam int SW   = DBB_DW / 8;

  typedef enum logic [2:0] {
    IDLE, REQ, WR_FILL, WR_BEAT, WR_RSP, RD_WAIT, RD_DRAIN
  } state_e;

  state_e              state_q, state_d;
  logic                init_q, init_d;
  logic                write_q, write_d;
  logic [DBB_AW-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [LEN_W-1:0]    bc_q, bc_d;
  logic [WI_W-1:0]     wi_q, wi_d;
  logic [DBB_DW-1:0]   wbuf_q, wbuf_d;
  logic [SW-1:0]       wstrb_q, wstrb_d;
  logic [DBB_DW-1:0]   rbuf_q, rbuf_d;
  logic                rlast_q, rlast_d;
  logic                done_q, done_d;
  logic                last_beat;
  logic                last_word;

  assign last_beat       = (bc_q == len_q - 1'b1);
  assign last_word       = (wi_q == WI_W'(R - 1));
  assign dbb_req_write_o = write_q;
  assign dbb_req_addr_o  = addr_q;
  assign dbb_req_len_o   = len_q;
  assign dbb_req_id_o    = id_q;
  assign dbb_wd_data_o   = wbuf_q;
  assign dbb_wd_strb_o   = wstrb_q;
  assign rd_s_strb_o     = 4'hF;
  assign done_o          = done_q;

  // NOTE: every output and _d is given a default before the case so no path infers a latch.
  always_comb begin
    state_d            = state_q;
    init_d             = 1'b1;
    write_d            = write_q;
    addr_d             = addr_q;
    len_d              = len_q;
    id_d               = id_q;
    bc_d               = bc_q;
    wi_d               = wi_q;
    wbuf_d             = wbuf_q;
    wstrb_d            = wstrb_q;
    rbuf_d             = rbuf_q;
    rlast_d            = rlast_q;
    done_d             = 1'b0;
    cmd_ready_o        = 1'b0;
    wr_s_ready_o       = 1'b0;
    rd_s_valid_o       = 1'b0;
    dbb_req_valid_o    = 1'b0;
    dbb_wd_valid_o     = 1'b0;
    dbb_wd_last_o      = 1'b0;
    dbb_wr_rsp_ready_o = 1'b0;
    dbb_rd_ready_o     = 1'b0;
    rd_s_data_o        = '0;

    for (int i = 0; i < R; i++) begin
      if (wi_q == WI_W'(i)) rd_s_data_o = rbuf_q[32*i +: 32];
    end

    unique case (state_q)
      IDLE: begin
        // init_q keeps cmd_ready low for the first cycle after reset or clear.
        cmd_ready_o = init_q;
        if (cmd_valid_i && init_q) begin
          write_d = cmd_write_i;
          addr_d  = cmd_addr_i;
          len_d   = (cmd_len_i == '0) ? LEN_W'(1) : cmd_len_i;
          id_d    = cmd_id_i;
          bc_d    = '0;
          wi_d    = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        dbb_req_valid_o = 1'b1;
        if (dbb_req_ready_i) state_d = write_q ? WR_FILL : RD_WAIT;
      end
      WR_FILL: begin
        wr_s_ready_o = 1'b1;
        if (wr_s_valid_i) begin
          for (int i = 0; i < R; i++) begin
            if (wi_q == WI_W'(i)) begin
              wbuf_d[32*i +: 32] = wr_s_data_i;
              wstrb_d[4*i +: 4]  = wr_s_strb_i;
            end
          end
          if (last_word) begin
            wi_d    = '0;
            state_d = WR_BEAT;
          end else begin
            wi_d = wi_q + 1'b1;
          end
        end
      end
      WR_BEAT: begin
        dbb_wd_valid_o = 1'b1;
        dbb_wd_last_o  = last_beat;
        if (dbb_wd_ready_i) begin
          bc_d    = last_beat ? '0 : bc_q + 1'b1;
          state_d = last_beat ? WR_RSP : WR_FILL;
        end
      end
      WR_RSP: begin
        dbb_wr_rsp_ready_o = 1'b1;
        if (dbb_wr_rsp_valid_i) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      RD_WAIT: begin
        dbb_rd_ready_o = 1'b1;
        if (dbb_rd_valid_i) begin
          rbuf_d  = dbb_rd_data_i;
          rlast_d = dbb_rd_last_i | last_beat;
          bc_d    = last_beat ? '0 : bc_q + 1'b1;
          wi_d    = '0;
          state_d = RD_DRAIN;
        end
      end
      RD_DRAIN: begin
        rd_s_valid_o = 1'b1;
        if (rd_s_ready_i) begin
          if (last_word) begin
            wi_d = '0;
            if (rlast_q) begin
              done_d  = 1'b1;
              state_d = IDLE;
            end else begin
              state_d = RD_WAIT;
            end
          end else begin
            wi_d = wi_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (clear_i) begin
      state_d = IDLE;
      init_d  = 1'b0;
      write_d = 1'b0;
      addr_d  = '0;
      len_d   = '0;
      id_d    = '0;
      bc_d    = '0;
      wi_d    = '0;
      wbuf_d  = '0;
      wstrb_d = '0;
      rbuf_d  = '0;
      rlast_d = 1'b0;
      done_d  = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      init_q  <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      len_q   <= '0;
      id_q    <= '0;
      bc_q    <= '0;
      wi_q    <= '0;
      wbuf_q  <= '0;
      wstrb_q <= '0;
      rbuf_q  <= '0;
      rlast_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      init_q  <= init_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      id_q    <= id_d;
      bc_q    <= bc_d;
      wi_q    <= wi_d;
      wbuf_q  <= wbuf_d;
      wstrb_q <= wstrb_d;
      rbuf_q  <= rbuf_d;
      rlast_q <= rlast_d;
      done_q  <= done_d;
    end
  end

`ifdef NVDLA_DBB_INIT_ID_CHECK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (state_q == WR_RSP && dbb_wr_rsp_valid_i && dbb_wr_rsp_id_i != id_q) err_d = 1'b1;
    if (state_q == RD_WAIT && dbb_rd_valid_i && dbb_rd_id_i != id_q) err_d = 1'b1;
    if (clear_i) err_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) err_q <= 1'b0;
    else         err_q <= err_d;
  end

  assign err_o = err_q;
`else
  logic unused_ids;
  assign unused_ids = ^{dbb_wr_rsp_id_i, dbb_rd_id_i};
  assign err_o      = 1'b0;
`endif

endmodule

// File: tb/tb_nvdla_dbb_initiator.sv
// Directed self-checking bench for nvdla_dbb_initiator (DBB_DW=64, so two words per beat).
module tb_nvdla_dbb_initiator;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        clear_i = 1'b0;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic        cmd_write_i = 1'b0;
  logic [63:0] cmd_addr_i = '0;
  logic [7:0]  cmd_len_i = '0;
  logic [7:0]  cmd_id_i = '0;
  logic        wr_s_valid_i = 1'b0;
  logic        wr_s_ready_o;
  logic [31:0] wr_s_data_i = '0;
  logic [3:0]  wr_s_strb_i = '0;
  logic        rd_s_valid_o;
  logic        rd_s_ready_i = 1'b0;
  logic [31:0] rd_s_data_o;
  logic [3:0]  rd_s_strb_o;
  logic        dbb_req_valid_o;
  logic        dbb_req_ready_i = 1'b0;
  logic        dbb_req_write_o;
  logic [63:0] dbb_req_addr_o;
  logic [7:0]  dbb_req_len_o;
  logic [7:0]  dbb_req_id_o;
  logic        dbb_wd_valid_o;
  logic        dbb_wd_ready_i = 1'b0;
  logic [63:0] dbb_wd_data_o;
  logic [7:0]  dbb_wd_strb_o;
  logic        dbb_wd_last_o;
  logic        dbb_wr_rsp_valid_i = 1'b0;
  logic        dbb_wr_rsp_ready_o;
  logic [7:0]  dbb_wr_rsp_id_i = '0;
  logic        dbb_rd_valid_i = 1'b0;
  logic        dbb_rd_ready_o;
  logic [63:0] dbb_rd_data_i = '0;
  logic [7:0]  dbb_rd_id_i = '0;
  logic        dbb_rd_last_i = 1'b0;
  logic        done_o;
  logic        err_o;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int req_cnt = 0;

  nvdla_dbb_initiator dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
    .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i), .cmd_id_i(cmd_id_i),
    .wr_s_valid_i(wr_s_valid_i), .wr_s_ready_o(wr_s_ready_o),
    .wr_s_data_i(wr_s_data_i), .wr_s_strb_i(wr_s_strb_i),
    .rd_s_valid_o(rd_s_valid_o), .rd_s_ready_i(rd_s_ready_i),
    .rd_s_data_o(rd_s_data_o), .rd_s_strb_o(rd_s_strb_o),
    .dbb_req_valid_o(dbb_req_valid_o), .dbb_req_ready_i(dbb_req_ready_i),
    .dbb_req_write_o(dbb_req_write_o), .dbb_req_addr_o(dbb_req_addr_o),
    .dbb_req_len_o(dbb_req_len_o), .dbb_req_id_o(dbb_req_id_o),
    .dbb_wd_valid_o(dbb_wd_valid_o), .dbb_wd_ready_i(dbb_wd_ready_i),
    .dbb_wd_data_o(dbb_wd_data_o), .dbb_wd_strb_o(dbb_wd_strb_o), .dbb_wd_last_o(dbb_wd_last_o),
    .dbb_wr_rsp_valid_i(dbb_wr_rsp_valid_i), .dbb_wr_rsp_ready_o(dbb_wr_rsp_ready_o),
    .dbb_wr_rsp_id_i(dbb_wr_rsp_id_i),
    .dbb_rd_valid_i(dbb_rd_valid_i), .dbb_rd_ready_o(dbb_rd_ready_o),
    .dbb_rd_data_i(dbb_rd_data_i), .dbb_rd_id_i(dbb_rd_id_i), .dbb_rd_last_i(dbb_rd_last_i),
    .done_o(done_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) begin
    if (done_o) done_cnt++;
    if (dbb_req_valid_o && dbb_req_ready_i) req_cnt++;
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic issue_cmd(input logic w, input logic [63:0] a, input logic [7:0] l,
                           input logic [7:0] i, output bit ok);
    int n = 0;
    cmd_valid_i = 1'b1; cmd_write_i = w; cmd_addr_i = a; cmd_len_i = l; cmd_id_i = i;
    while (!cmd_ready_o && n < 100) begin tick(); n++; end
    ok = cmd_ready_o;
    tick();
    cmd_valid_i = 1'b0;
  endtask

  task automatic accept_req(input bit stall, output bit ok, output logic w,
                            output logic [63:0] a, output logic [7:0] l, output logic [7:0] i);
    int n = 0;
    ok = 1'b1;
    while (!dbb_req_valid_o && n < 100) begin tick(); n++; end
    w = dbb_req_write_o; a = dbb_req_addr_o; l = dbb_req_len_o; i = dbb_req_id_o;
    if (!dbb_req_valid_o) begin ok = 1'b0; return; end
    if (stall) repeat ($urandom_range(1, 3)) begin
      tick();
      if (!dbb_req_valid_o || dbb_req_addr_o !== a || dbb_req_len_o !== l || dbb_req_id_o !== i)
        ok = 1'b0;
    end
    dbb_req_ready_i = 1'b1;
    tick();
    dbb_req_ready_i = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] d, input logic [3:0] s, output bit ok);
    int n = 0;
    wr_s_valid_i = 1'b1; wr_s_data_i = d; wr_s_strb_i = s;
    while (!wr_s_ready_o && n < 100) begin tick(); n++; end
    ok = wr_s_ready_o;
    tick();
    wr_s_valid_i = 1'b0;
  endtask

  task automatic take_beat(input bit stall, output bit ok, output logic [63:0] d,
                           output logic [7:0] s, output logic last);
    int n = 0;
    ok = 1'b1;
    while (!dbb_wd_valid_o && n < 100) begin tick(); n++; end
    d = dbb_wd_data_o; s = dbb_wd_strb_o; last = dbb_wd_last_o;
    if (!dbb_wd_valid_o) begin ok = 1'b0; return; end
    if (stall) repeat ($urandom_range(1, 3)) begin
      tick();
      if (!dbb_wd_valid_o || dbb_wd_data_o !== d || dbb_wd_strb_o !== s || dbb_wd_last_o !== last)
        ok = 1'b0;
    end
    dbb_wd_ready_i = 1'b1;
    tick();
    dbb_wd_ready_i = 1'b0;
  endtask

  task automatic give_rsp(input logic [7:0] i, output bit ok);
    int n = 0;
    dbb_wr_rsp_valid_i = 1'b1; dbb_wr_rsp_id_i = i;
    while (!dbb_wr_rsp_ready_o && n < 100) begin tick(); n++; end
    ok = dbb_wr_rsp_ready_o;
    tick();
    dbb_wr_rsp_valid_i = 1'b0;
  endtask

  task automatic give_beat(input logic [63:0] d, input logic [7:0] i, input logic last, output bit ok);
    int n = 0;
    dbb_rd_valid_i = 1'b1; dbb_rd_data_i = d; dbb_rd_id_i = i; dbb_rd_last_i = last;
    while (!dbb_rd_ready_o && n < 100) begin tick(); n++; end
    ok = dbb_rd_ready_o;
    tick();
    dbb_rd_valid_i = 1'b0; dbb_rd_last_i = 1'b0;
  endtask

  task automatic recv_word(input bit stall, output bit ok, output logic [31:0] d, output logic [3:0] s);
    int n = 0;
    ok = 1'b1;
    while (!rd_s_valid_o && n < 100) begin tick(); n++; end
    d = rd_s_data_o; s = rd_s_strb_o;
    if (!rd_s_valid_o) begin ok = 1'b0; return; end
    if (stall) repeat ($urandom_range(1, 3)) begin
      tick();
      if (!rd_s_valid_o || rd_s_data_o !== d) ok = 1'b0;
    end
    rd_s_ready_i = 1'b1;
    tick();
    rd_s_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    #12;
    checks++;
    if ({cmd_ready_o, wr_s_ready_o, rd_s_valid_o, dbb_req_valid_o, dbb_wd_valid_o,
         dbb_wr_rsp_ready_o, dbb_rd_ready_o, done_o, err_o} !== 9'b0) begin
      failures++; $display("FAIL reset_ctrl got=%b exp=0", {cmd_ready_o, wr_s_ready_o, rd_s_valid_o,
        dbb_req_valid_o, dbb_wd_valid_o, dbb_wr_rsp_ready_o, dbb_rd_ready_o, done_o, err_o});
    end
    checks++;
    if ({dbb_req_addr_o, dbb_wd_data_o, rd_s_data_o} !== '0) begin
      failures++; $display("FAIL reset_data got=%h/%h/%h exp=0", dbb_req_addr_o, dbb_wd_data_o, rd_s_data_o);
    end
    rst_ni = 1'b1;
    tick(); tick();
    checks++;
    if (cmd_ready_o !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready_o); end
  endtask

  task automatic run_write(input bit stall, input logic [7:0] id, input logic [31:0] w0,
                           input logic [31:0] w1, input logic [31:0] w2, input logic [31:0] w3);
    bit ok, okr, okb0, okb1; bit okw = 1'b1;
    logic rw, l0, l1; logic [63:0] ra, d0, d1; logic [7:0] rl, ri, s0, s1;
    int done0 = done_cnt, req0 = req_cnt;
    issue_cmd(1'b1, 64'h0000_0000_0000_1000, 8'd2, id, ok);
    accept_req(stall, okr, rw, ra, rl, ri);
    checks++;
    if (!ok || !okr || rw !== 1'b1 || ra !== 64'h1000 || rl !== 8'd2 || ri !== id) begin
      failures++; $display("FAIL wr_req ok=%b stable=%b got w=%b a=%h l=%0d id=%h exp w=1 a=1000 l=2 id=%h",
        ok, okr, rw, ra, rl, ri, id);
    end
    send_word(w0, 4'hF, ok); okw &= ok; send_word(w1, 4'hF, ok); okw &= ok;
    take_beat(stall, okb0, d0, s0, l0);
    send_word(w2, 4'hF, ok); okw &= ok; send_word(w3, 4'hF, ok); okw &= ok;
    take_beat(stall, okb1, d1, s1, l1);
    checks++;
    if (!okw || !okb0 || d0 !== {w1, w0} || s0 !== 8'hFF || l0 !== 1'b0) begin
      failures++; $display("FAIL wr_beat0 ok=%b/%b got=%h strb=%h last=%b exp=%h strb=ff last=0",
        okw, okb0, d0, s0, l0, {w1, w0});
    end
    checks++;
    if (!okb1 || d1 !== {w3, w2} || s1 !== 8'hFF || l1 !== 1'b1) begin
      failures++; $display("FAIL wr_beat1 ok=%b got=%h strb=%h last=%b exp=%h strb=ff last=1",
        okb1, d1, s1, l1, {w3, w2});
    end
    give_rsp(id, ok);
    checks++;
    if (!ok || done_o !== 1'b1) begin failures++; $display("FAIL wr_done ok=%b got=%b exp=1", ok, done_o); end
    tick();
    checks++;
    if (done_cnt - done0 != 1 || req_cnt - req0 != 1 || cmd_ready_o !== 1'b1) begin
      failures++; $display("FAIL wr_counts done=%0d req=%0d ready=%b exp 1 1 1",
        done_cnt - done0, req_cnt - req0, cmd_ready_o);
    end
  endtask

  task automatic test_write();
    run_write(1'b0, 8'h5A, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
  endtask

  task automatic run_read(input bit stall, input logic [7:0] len, input int beats);
    bit ok, okr; bit okall = 1'b1;
    logic rw; logic [63:0] ra; logic [7:0] rl, ri;
    logic [31:0] got; logic [3:0] st;
    logic [31:0] exp_w [6];
    int done0 = done_cnt;
    exp_w = '{32'h0000B0A0, 32'h0, 32'h0000D0C0, 32'h0, 32'h0000F0E0, 32'h0};
    issue_cmd(1'b0, 64'h0000_0001_0000_0040, len, 8'h21, ok);
    accept_req(stall, okr, rw, ra, rl, ri);
    checks++;
    if (!ok || !okr || rw !== 1'b0 || ra !== 64'h0000_0001_0000_0040 || rl !== 8'(beats) || ri !== 8'h21) begin
      failures++; $display("FAIL rd_req ok=%b/%b got w=%b a=%h l=%0d id=%h exp w=0 a=100000040 l=%0d id=21",
        ok, okr, rw, ra, rl, ri, beats);
    end
    for (int b = 0; b < beats; b++) begin
      give_beat({32'h0, exp_w[2*b]}, 8'h21, b == beats - 1 && len != 0, ok);
      okall &= ok;
      for (int k = 0; k < 2; k++) begin
        recv_word(stall, ok, got, st);
        checks++;
        if (!okall || !ok || got !== exp_w[2*b+k] || st !== 4'hF) begin
          failures++; $display("FAIL rd_word%0d ok=%b/%b got=%h strb=%h exp=%h strb=f",
            2*b+k, okall, ok, got, st, exp_w[2*b+k]);
        end
        if (!(b == beats - 1 && k == 1)) begin
          checks++;
          if (done_o !== 1'b0) begin failures++; $display("FAIL rd_early_done word%0d got=1 exp=0", 2*b+k); end
        end
      end
    end
    checks++;
    if (done_o !== 1'b1) begin failures++; $display("FAIL rd_done got=%b exp=1", done_o); end
    tick();
    checks++;
    if (done_cnt - done0 != 1 || cmd_ready_o !== 1'b1 || dbb_rd_ready_o !== 1'b0) begin
      failures++; $display("FAIL rd_end done=%0d ready=%b rd_ready=%b exp 1 1 0",
        done_cnt - done0, cmd_ready_o, dbb_rd_ready_o);
    end
  endtask

  task automatic test_read();
    run_read(1'b0, 8'd3, 3);
  endtask

  task automatic test_back_pressure();
    run_write(1'b1, 8'h33, 32'hCAFE0001, 32'hCAFE0002, 32'hCAFE0003, 32'hCAFE0004);
    run_read(1'b1, 8'd2, 2);
  endtask

  task automatic test_len_zero();
    run_read(1'b0, 8'd0, 1);
  endtask

  task automatic test_reset_mid_write();
    bit ok, okr, okb; logic rw, last; logic [63:0] ra, d; logic [7:0] rl, ri, s;
    issue_cmd(1'b1, 64'h2000, 8'd1, 8'h77, ok);
    accept_req(1'b0, okr, rw, ra, rl, ri);
    send_word(32'hDEADBEEF, 4'hF, ok);
    rst_ni = 1'b0;
    #1;
    checks++;
    if ({cmd_ready_o, wr_s_ready_o, dbb_wd_valid_o, dbb_req_valid_o, done_o} !== 5'b0 ||
        dbb_wd_data_o !== '0 || dbb_req_addr_o !== '0) begin
      failures++; $display("FAIL rstmid_outputs got=%b data=%h addr=%h exp=0",
        {cmd_ready_o, wr_s_ready_o, dbb_wd_valid_o, dbb_req_valid_o, done_o}, dbb_wd_data_o, dbb_req_addr_o);
    end
    #3 rst_ni = 1'b1;
    tick(); tick();
    checks++;
    if (cmd_ready_o !== 1'b1 || wr_s_ready_o !== 1'b0) begin
      failures++; $display("FAIL rstmid_idle cmd_ready=%b wr_ready=%b exp 1 0", cmd_ready_o, wr_s_ready_o);
    end
    issue_cmd(1'b1, 64'h3000, 8'd1, 8'h78, ok);
    accept_req(1'b0, okr, rw, ra, rl, ri);
    send_word(32'hAAAAAAAA, 4'h3, ok);
    send_word(32'hBBBBBBBB, 4'hC, ok);
    take_beat(1'b0, okb, d, s, last);
    checks++;
    if (!okb || d !== 64'hBBBBBBBB_AAAAAAAA || s !== 8'hC3 || last !== 1'b1) begin
      failures++; $display("FAIL rstmid_beat ok=%b got=%h strb=%h last=%b exp=bbbbbbbbaaaaaaaa strb=c3 last=1",
        okb, d, s, last);
    end
    give_rsp(8'h78, ok);
    checks++;
    if (!ok || done_o !== 1'b1) begin failures++; $display("FAIL rstmid_done ok=%b got=%b exp=1", ok, done_o); end
    tick();
  endtask

  task automatic test_clear();
    bit ok;
    issue_cmd(1'b0, 64'h4000, 8'd1, 8'h01, ok);
    clear_i = 1'b1; dbb_req_ready_i = 1'b1;
    tick();
    clear_i = 1'b0; dbb_req_ready_i = 1'b0;
    checks++;
    if (!ok || dbb_req_valid_o !== 1'b0 || dbb_rd_ready_o !== 1'b0 || cmd_ready_o !== 1'b0 ||
        dbb_req_addr_o !== '0) begin
      failures++; $display("FAIL clear_prio ok=%b req_v=%b rd_r=%b cmd_r=%b addr=%h exp 1 0 0 0 0",
        ok, dbb_req_valid_o, dbb_rd_ready_o, cmd_ready_o, dbb_req_addr_o);
    end
    tick();
    checks++;
    if (cmd_ready_o !== 1'b1) begin failures++; $display("FAIL clear_ready got=%b exp=1", cmd_ready_o); end
  endtask

  task automatic test_id_check();
    bit ok, okr, okb; logic rw, last; logic [63:0] ra, d; logic [7:0] rl, ri, s;
    issue_cmd(1'b1, 64'h5000, 8'd1, 8'h5A, ok);
    accept_req(1'b0, okr, rw, ra, rl, ri);
    send_word(32'h1, 4'hF, ok);
    send_word(32'h2, 4'hF, ok);
    take_beat(1'b0, okb, d, s, last);
    give_rsp(8'h5B, ok);
`ifdef NVDLA_DBB_INIT_ID_CHECK_EN
    checks++;
    if (!ok || err_o !== 1'b1 || done_o !== 1'b1) begin
      failures++; $display("FAIL idchk_err ok=%b err=%b done=%b exp 1 1", ok, err_o, done_o);
    end
    tick(); tick();
    checks++;
    if (err_o !== 1'b1) begin failures++; $display("FAIL idchk_sticky got=%b exp=1", err_o); end
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    checks++;
    if (err_o !== 1'b0) begin failures++; $display("FAIL idchk_clear got=%b exp=0", err_o); end
    tick();
`else
    checks++;
    if (!ok || err_o !== 1'b0 || done_o !== 1'b1) begin
      failures++; $display("FAIL id_ignored ok=%b err=%b done=%b exp err=0 done=1", ok, err_o, done_o);
    end
    tick();
`endif
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_pressure();
    test_len_zero();
    test_reset_mid_write();
    test_clear();
    test_id_check();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
